detector_vazamento: RTL and testbench
=====================================

DETECTOR_VAZAMENTO -- requirements
Module: detector_vazamento

Interface
REQ-001 Parameters SHALL be: PROFUNDIDADE, 8, window depth in samples; LIMIAR, 5, leak threshold in cm; CONFIRMA, 3, consecutive over-threshold windows needed to alarm.
REQ-002 clock  in  1  system clock (50 MHz); one clock domain only.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 zera  in  1  synchronous clear, active-high.
REQ-005 amostra  in  1  one-cycle pulse: new classified average available (fim_classificacao & ~descartar_medida).
REQ-006 distancia  in  12  averaged distance, 3 BCD digits (cm), sensor-to-water.
REQ-007 valvula_aberta  in  1  fill valve state (abrir_valv).
REQ-008 reconhece  in  1  operator acknowledge; clears alarm.
REQ-009 vazamento  out  1  sticky leak alarm.
REQ-010 delta  out  11  signed two's-complement newest minus oldest window sample, binary cm.
REQ-011 pronto  out  1  one-cycle pulse: sample processed.
REQ-012 erro_bcd  out  1  one-cycle pulse: sample rejected, invalid BCD digit.
REQ-013 cheio  out  1  window holds PROFUNDIDADE samples.
REQ-014 db_estado  out  2  FSM state code; db_contagem  out  4  valid sample count.

Function
REQ-015 FSM states SHALL be OCIOSO(00), CONVERTE(01), ESCREVE(10), AVALIA(11).
REQ-016 OCIOSO: on amostra, with valvula_aberta=0, capture distancia -> CONVERTE; otherwise stay.
REQ-017 CONVERTE: convert BCD to binary (d2*100+d1*10+d0, 10 bits); any digit >9 -> erro_bcd pulse, buffer untouched, -> OCIOSO; else -> ESCREVE.
REQ-018 ESCREVE: if count==PROFUNDIDADE, delta = new - entry[wptr] (oldest), else delta = 0; write new at wptr; wptr wraps PROFUNDIDADE-1 -> 0; count saturates at PROFUNDIDADE; -> AVALIA.
REQ-019 AVALIA: evaluate only if a full-window delta was produced; delta > LIMIAR increments confirm counter (saturating), else clears it; confirm reaching CONFIRMA sets vazamento; assert pronto; -> OCIOSO.
REQ-020 Latency: amostra at cycle t -> pronto at t+3 (erro_bcd at t+2).
REQ-021 amostra arriving outside OCIOSO SHALL be ignored.
REQ-022 valvula_aberta=1 in any state SHALL clear count, wptr, confirm counter, set cheio=0, return to OCIOSO; vazamento unchanged; coincident amostra discarded.
REQ-023 reconhece clears vazamento and confirm counter; coincident set condition in AVALIA wins (vazamento stays 1).
REQ-024 zera SHALL have the same effect as reset; zera wins over every coincident event.
REQ-025 delta holds its last value until the next ESCREVE or clear.

Reset
REQ-026 On reset low: state OCIOSO; count, wptr, confirm, delta = 0; vazamento, pronto, erro_bcd, cheio = 0; buffer contents are don't-care.
REQ-027 Reset release SHALL take effect on the next rising clock edge with no spurious pronto.

Structure
REQ-028 State codes and parameter defaults SHALL live in the shared project package/include.
REQ-029 BCD conversion SHALL be a sub-module bcd_para_binario (12-bit BCD in, 10-bit binary out, invalid flag), combinational.
REQ-030 Buffer SHALL be a register array, PROFUNDIDADE x 10 bits, with no reset on contents.

Verification
REQ-031 Reset mid-AVALIA -> all outputs 0 next cycle; db_estado=00.
REQ-032 9 samples of 0x100, valve closed -> pronto at t+3 each, cheio after 8th, delta=0, vazamento=0.
REQ-033 Ramp 100..110 cm (+1/sample) -> delta=8 from 9th sample; vazamento=1 at 11th sample's pronto.
REQ-034 valvula_aberta pulsed after 10th ramp sample -> db_contagem=0, cheio=0, vazamento=0; ramp resumes, alarm needs 8+3 samples again.
REQ-035 distancia=0x1A0 -> erro_bcd at t+2, no pronto, db_contagem unchanged.
REQ-036 reconhece in same cycle as alarm-setting AVALIA -> vazamento=1; reconhece alone later -> 0.

Source files
------------

// File: rtl/detector_vazamento_pkg.sv
// Shared state codes and parameter defaults for the leak detector.
package detector_vazamento_pkg;

    localparam int unsigned PROFUNDIDADE_PADRAO = 8;
    localparam int unsigned LIMIAR_PADRAO       = 5;
    localparam int unsigned CONFIRMA_PADRAO     = 3;

    typedef enum logic [1:0] {
        Ocioso   = 2'b00,
        Converte = 2'b01,
        Escreve  = 2'b10,
        Avalia   = 2'b11
    } estado_t;

endpackage

// File: rtl/bcd_para_binario.sv
// Combinational 3-digit BCD to 10-bit binary converter with invalid-digit flag.
module bcd_para_binario (
    input  logic [11:0] bcd,
    output logic [9:0]  binario,
    output logic        invalido
);

    logic [3:0] d2, d1, d0;

    always_comb begin
        d2       = bcd[11:8];
        d1       = bcd[7:4];
        d0       = bcd[3:0];
        invalido = (d2 > 4'd9) || (d1 > 4'd9) || (d0 > 4'd9);
        binario  = 10'(d2) * 10'd100 + 10'(d1) * 10'd10 + 10'(d0);
    end

endmodule

// File: rtl/detector_vazamento.sv
// Leak detector: sliding window of water-level samples; alarms after CONFIRMA
// consecutive windows whose newest-minus-oldest distance exceeds LIMIAR.
module detector_vazamento
    import detector_vazamento_pkg::*;
#(
    parameter int unsigned PROFUNDIDADE = PROFUNDIDADE_PADRAO,
    parameter int unsigned LIMIAR       = LIMIAR_PADRAO,
    parameter int unsigned CONFIRMA     = CONFIRMA_PADRAO
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        zera,
    input  logic        amostra,
    input  logic [11:0] distancia,
    input  logic        valvula_aberta,
    input  logic        reconhece,
    output logic        vazamento,
    output logic [10:0] delta,
    output logic        pronto,
    output logic        erro_bcd,
    output logic        cheio,
    output logic [1:0]  db_estado,
    output logic [3:0]  db_contagem
);

    localparam int unsigned PTR_W  = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
    localparam int unsigned CNT_W  = $clog2(PROFUNDIDADE + 1);
    localparam int unsigned CONF_W = $clog2(CONFIRMA + 1);
    localparam logic signed [10:0] LIMIAR_S = 11'(LIMIAR);

    estado_t           estado_q, estado_d;
    logic [11:0]       bcd_q, bcd_d;
    logic [9:0]        bin_q, bin_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [CNT_W-1:0]  cont_q, cont_d;
    logic [CONF_W-1:0] conf_q, conf_d, conf_n;
    logic [10:0]       delta_q, delta_d;
    logic              dvalido_q, dvalido_d;
    logic              vaz_q, vaz_d;
    logic              erro_q, erro_d;
    logic              escreve, set_alarme, pronto_c;

    logic [9:0]        buffer [PROFUNDIDADE];
    logic [9:0]        bin_conv;
    logic              bcd_invalido;

    bcd_para_binario u_bcd (
        .bcd      (bcd_q),
        .binario  (bin_conv),
        .invalido (bcd_invalido)
    );

    always_comb begin
        estado_d   = estado_q;
        bcd_d      = bcd_q;
        bin_d      = bin_q;
        wptr_d     = wptr_q;
        cont_d     = cont_q;
        conf_d     = conf_q;
        conf_n     = '0;
        delta_d    = delta_q;
        dvalido_d  = dvalido_q;
        vaz_d      = vaz_q;
        erro_d     = 1'b0;
        escreve    = 1'b0;
        set_alarme = 1'b0;
        pronto_c   = 1'b0;

        if (zera) begin
            estado_d  = Ocioso;
            wptr_d    = '0;
            cont_d    = '0;
            conf_d    = '0;
            delta_d   = '0;
            dvalido_d = 1'b0;
            vaz_d     = 1'b0;
        end else if (valvula_aberta) begin
            // Filling invalidates the window, but a pending alarm is kept.
            estado_d  = Ocioso;
            wptr_d    = '0;
            cont_d    = '0;
            conf_d    = '0;
            dvalido_d = 1'b0;
        end else begin
            if (reconhece) begin
                vaz_d  = 1'b0;
                conf_d = '0;
            end
            unique case (estado_q)
                Ocioso: begin
                    if (amostra) begin
                        bcd_d    = distancia;
                        estado_d = Converte;
                    end
                end
                Converte: begin
                    if (bcd_invalido) begin
                        erro_d   = 1'b1;
                        estado_d = Ocioso;
                    end else begin
                        bin_d    = bin_conv;
                        estado_d = Escreve;
                    end
                end
                Escreve: begin
                    escreve = 1'b1;
                    if (cont_q == CNT_W'(PROFUNDIDADE)) begin
                        delta_d   = {1'b0, bin_q} - {1'b0, buffer[wptr_q]};
                        dvalido_d = 1'b1;
                    end else begin
                        delta_d   = '0;
                        dvalido_d = 1'b0;
                    end
                    wptr_d = (wptr_q == PTR_W'(PROFUNDIDADE - 1)) ? '0 : wptr_q + PTR_W'(1);
                    if (cont_q != CNT_W'(PROFUNDIDADE)) begin
                        cont_d = cont_q + CNT_W'(1);
                    end
                    estado_d = Avalia;
                end
                Avalia: begin
                    pronto_c = 1'b1;
                    if (dvalido_q) begin
                        if ($signed(delta_q) > LIMIAR_S) begin
                            conf_n = (conf_q == CONF_W'(CONFIRMA)) ? conf_q : conf_q + CONF_W'(1);
                        end
                        if (!reconhece) begin
                            conf_d = conf_n;
                        end
                        // Alarm setting overrides a coincident acknowledge.
                        if (conf_n == CONF_W'(CONFIRMA)) begin
                            vaz_d      = 1'b1;
                            set_alarme = 1'b1;
                        end
                    end
                    estado_d = Ocioso;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= Ocioso;
            bcd_q     <= '0;
            bin_q     <= '0;
            wptr_q    <= '0;
            cont_q    <= '0;
            conf_q    <= '0;
            delta_q   <= '0;
            dvalido_q <= 1'b0;
            vaz_q     <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            wptr_q    <= wptr_d;
            cont_q    <= cont_d;
            conf_q    <= conf_d;
            delta_q   <= delta_d;
            dvalido_q <= dvalido_d;
            vaz_q     <= vaz_d;
            erro_q    <= erro_d;
        end
    end

    always_ff @(posedge clock) begin
        if (escreve) begin
            buffer[wptr_q] <= bin_q;
        end
    end

    always_comb begin
        vazamento   = vaz_q | set_alarme;
        delta       = delta_q;
        pronto      = pronto_c;
        erro_bcd    = erro_q;
        cheio       = (cont_q == CNT_W'(PROFUNDIDADE));
        db_estado   = estado_q;
        db_contagem = 4'(cont_q);
    end

endmodule

// File: tb/tb_detector_vazamento.sv
// Scoreboard bench for detector_vazamento: directed samples, monitor checks each pronto/erro_bcd.
module tb_detector_vazamento;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        zera = 1'b0;
    logic        amostra = 1'b0;
    logic [11:0] distancia = '0;
    logic        valvula_aberta = 1'b0;
    logic        reconhece = 1'b0;
    logic        vazamento;
    logic [10:0] delta;
    logic        pronto;
    logic        erro_bcd;
    logic        cheio;
    logic [1:0]  db_estado;
    logic [3:0]  db_contagem;

    detector_vazamento dut (
        .clock          (clock),
        .reset          (reset),
        .zera           (zera),
        .amostra        (amostra),
        .distancia      (distancia),
        .valvula_aberta (valvula_aberta),
        .reconhece      (reconhece),
        .vazamento      (vazamento),
        .delta          (delta),
        .pronto         (pronto),
        .erro_bcd       (erro_bcd),
        .cheio          (cheio),
        .db_estado      (db_estado),
        .db_contagem    (db_contagem)
    );

    always #10 clock = ~clock;

    typedef struct {
        int ciclo;
        int delta;
        bit vaz;
        bit cheio;
        int cont;
    } exp_t;

    typedef struct {
        int ciclo;
        int cont;
    } erro_t;

    exp_t  fila_pronto [$];
    erro_t fila_erro [$];
    exp_t  mon_e;
    erro_t mon_r;
    int    cyc = 0;
    int    n_total = 0;
    int    n_ok = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nome, input int obtido, input int esperado);
        n_total++;
        if (obtido == esperado) n_ok++;
        else $display("FAIL %s: obtido %0d esperado %0d (ciclo %0d)", nome, obtido, esperado, cyc);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int sat8(input int i);
        return (i < 8) ? i : 8;
    endfunction

    // Issue one sample; expected pronto lands three cycles after the drive cycle.
    task automatic enviar(input logic [11:0] d, input int e_delta, input bit e_vaz,
                          input int e_cont, input bit ack, input int largura);
        exp_t e;
        int   k;
        k       = cyc;
        e.ciclo = k + 3;
        e.delta = e_delta;
        e.vaz   = e_vaz;
        e.cheio = (e_cont == 8);
        e.cont  = e_cont;
        fila_pronto.push_back(e);
        distancia = d;
        amostra   = 1'b1;
        tick();
        if (largura > 1) tick();
        amostra = 1'b0;
        while (cyc < k + 3) tick();
        reconhece = ack;
        tick();
        reconhece = 1'b0;
        tick();
    endtask

    task automatic enviar_invalido(input logic [11:0] d, input int e_cont);
        erro_t r;
        r.ciclo = cyc + 2;
        r.cont  = e_cont;
        fila_erro.push_back(r);
        distancia = d;
        amostra   = 1'b1;
        tick();
        amostra = 1'b0;
        repeat (4) tick();
    endtask

    always @(negedge clock) begin
        if (pronto) begin
            if (fila_pronto.size() == 0) begin
                chk("pronto_inesperado", 1, 0);
            end else begin
                mon_e = fila_pronto.pop_front();
                chk("pronto_ciclo", cyc, mon_e.ciclo);
                chk("delta", int'($signed(delta)), mon_e.delta);
                chk("vazamento", int'(vazamento), int'(mon_e.vaz));
                chk("cheio", int'(cheio), int'(mon_e.cheio));
                chk("db_contagem", int'(db_contagem), mon_e.cont);
            end
        end
        if (erro_bcd) begin
            if (fila_erro.size() == 0) begin
                chk("erro_inesperado", 1, 0);
            end else begin
                mon_r = fila_erro.pop_front();
                chk("erro_ciclo", cyc, mon_r.ciclo);
                chk("erro_contagem", int'(db_contagem), mon_r.cont);
            end
        end
    end

    initial begin
        tick();
        chk("rst_vazamento", int'(vazamento), 0);
        chk("rst_pronto", int'(pronto), 0);
        chk("rst_erro", int'(erro_bcd), 0);
        chk("rst_cheio", int'(cheio), 0);
        chk("rst_delta", int'(delta), 0);
        chk("rst_estado", int'(db_estado), 0);
        chk("rst_contagem", int'(db_contagem), 0);
        reset = 1'b1;
        repeat (2) tick();

        // Constant level: window fills, no movement, no alarm; sample 3 holds amostra 2 cycles.
        for (int i = 1; i <= 9; i++) enviar(12'h100, 0, 1'b0, sat8(i), 1'b0, (i == 3) ? 2 : 1);

        zera = 1'b1;
        tick();
        zera = 1'b0;
        chk("zera_contagem", int'(db_contagem), 0);
        chk("zera_cheio", int'(cheio), 0);

        // Ramp +1 cm/sample: delta 8 once full, alarm on the third such window.
        for (int i = 1; i <= 11; i++)
            enviar(to_bcd(99 + i), (i >= 9) ? 8 : 0, i >= 11, sat8(i), 1'b0, 1);
        chk("vaz_pegajoso", int'(vazamento), 1);
        reconhece = 1'b1;
        tick();
        reconhece = 1'b0;
        chk("reconhece_limpa", int'(vazamento), 0);

        // Alarm re-armed; acknowledge coincident with the setting evaluation loses.
        for (int i = 12; i <= 14; i++) enviar(to_bcd(99 + i), 8, i == 14, 8, i == 14, 1);
        chk("ack_coincidente", int'(vazamento), 1);
        reconhece = 1'b1;
        tick();
        reconhece = 1'b0;
        chk("reconhece_isolado", int'(vazamento), 0);

        enviar_invalido(12'h1A0, 8);
        chk("erro_contagem_mantida", int'(db_contagem), 8);
        // Oldest entry is 106 cm, so a 100 cm sample gives a negative delta.
        enviar(12'h100, -6, 1'b0, 8, 1'b0, 1);

        zera = 1'b1;
        tick();
        zera = 1'b0;
        for (int i = 1; i <= 10; i++)
            enviar(to_bcd(99 + i), (i >= 9) ? 8 : 0, 1'b0, sat8(i), 1'b0, 1);
        valvula_aberta = 1'b1;
        tick();
        valvula_aberta = 1'b0;
        chk("valv_contagem", int'(db_contagem), 0);
        chk("valv_cheio", int'(cheio), 0);
        chk("valv_vazamento", int'(vazamento), 0);
        for (int i = 1; i <= 11; i++)
            enviar(to_bcd(109 + i), (i >= 9) ? 8 : 0, i >= 11, sat8(i), 1'b0, 1);
        chk("valv_realarme", int'(vazamento), 1);

        // Asynchronous reset while evaluating.
        begin
            int k;
            k         = cyc;
            distancia = 12'h121;
            amostra   = 1'b1;
            tick();
            amostra = 1'b0;
            while (cyc < k + 3) tick();
            chk("pre_reset_estado", int'(db_estado), 3);
            reset = 1'b0;
            tick();
        end
        chk("rst_meio_vazamento", int'(vazamento), 0);
        chk("rst_meio_pronto", int'(pronto), 0);
        chk("rst_meio_cheio", int'(cheio), 0);
        chk("rst_meio_delta", int'(delta), 0);
        chk("rst_meio_estado", int'(db_estado), 0);
        chk("rst_meio_contagem", int'(db_contagem), 0);
        reset = 1'b1;
        repeat (5) tick();
        chk("fila_pronto_vazia", fila_pronto.size(), 0);
        chk("fila_erro_vazia", fila_erro.size(), 0);

        $display("%0d/%0d checks passed", n_ok, n_total);
        $finish;
    end

endmodule
